// File: rtl/rect_fill_if.sv
// rtl/rect_fill_if.sv - command-byte and arbiter-write bundle for rect_fill_engine
// Signals:
//   cmd_fifo_data/rts/rtr : command byte stream from the command processor
//   arb_data/addr/wben    : word write presented to the memory arbiter
//   arb_rts/arb_rtr       : write handshake
//   busy/done             : engine status
// Modports: master = engine side, slave = command source / arbiter side.
interface rect_fill_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 17
);
    logic [7:0]          cmd_fifo_data;
    logic                cmd_fifo_rtr;
    logic                cmd_fifo_rts;
    logic [DATA_W-1:0]   arb_data;
    logic [ADDR_W-1:0]   arb_addr;
    logic [DATA_W/8-1:0] arb_wben;
    logic                arb_rts;
    logic                arb_rtr;
    logic                busy;
    logic                done;

    modport master (
        input  cmd_fifo_data, cmd_fifo_rts, arb_rtr,
        output cmd_fifo_rtr, arb_data, arb_addr, arb_wben, arb_rts, busy, done
    );

    modport slave (
        output cmd_fifo_data, cmd_fifo_rts, arb_rtr,
        input  cmd_fifo_rtr, arb_data, arb_addr, arb_wben, arb_rts, busy, done
    );
endinterface

// File: rtl/rect_fill_engine.sv
// rtl/rect_fill_engine.sv - clipped rectangle fill/outline engine issuing coalesced word writes
// Ports:
//   clk  : clock
//   rst_ : synchronous active-low reset
//   bus  : rect_fill_if master - command bytes in, arbiter word writes out, busy/done
module rect_fill_engine #(
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 480,
    parameter int DATA_W    = 32,
    parameter int PIX_W     = 8,
    parameter int ADDR_W    = 17,
    parameter int BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        rst_,
    rect_fill_if.master bus
);
    localparam int PPW    = DATA_W / PIX_W;
    localparam int LB     = PIX_W / 8;
    localparam int NBYTES = 9 + LB;
    localparam int WPR    = FB_WIDTH / PPW;
    localparam int LW     = $clog2(PPW);
    localparam int CW     = $clog2(NBYTES);
    localparam logic [15:0] XMAX  = 16'(FB_WIDTH - 1);
    localparam logic [15:0] YMAX  = 16'(FB_HEIGHT - 1);
    localparam logic [15:0] LMASK = 16'(PPW - 1);

    typedef enum logic [2:0] {S_DECODE, S_CLIP, S_ROW, S_DRIVE, S_DONE} state_t;

    state_t              state;
    logic [CW-1:0]       byte_cnt;
    logic [15:0]         cmd_x, cmd_y, cmd_w, cmd_h;
    logic                cmd_outline;
    logic [PIX_W-1:0]    cmd_color;
    logic [15:0]         x1, y1, cy, cw;

    logic                rtr_q, rts_q, busy_q, done_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W/8-1:0] wben_q;

    // Clip results (meaningful in S_CLIP) and the span of the row being set up/driven.
    logic [16:0]         xe, ye;
    logic [15:0]         c_x1, c_y1;
    logic                c_empty;
    logic [15:0]         s_x1, s_y1, s_cy, s_wl, s_wr, pres_w;
    logic                s_edge;
    int                  s_lo, s_hi;
    logic [31:0]         row_lin;
    logic [PPW-1:0]      lane_m;
    logic [ADDR_W-1:0]   pres_addr;
    logic [DATA_W/8-1:0] pres_wben;

    // Lanes of word w touched by the span. A full span covers lo..PPW-1 in the
    // left word, 0..hi in the right word and everything between; an edge span
    // only touches pixel lo of the left word and pixel hi of the right word.
    function automatic logic [PPW-1:0] lanes(input logic [15:0] w, input logic [15:0] l,
                                             input logic [15:0] r, input int lo, input int hi,
                                             input logic edg);
        logic [PPW-1:0] m;
        m = '0;
        for (int k = 0; k < PPW; k++) begin
            if (edg) begin
                if ((w == l && k == lo) || (w == r && k == hi)) m[k] = 1'b1;
            end else if ((w != l || k >= lo) && (w != r || k <= hi)) begin
                m[k] = 1'b1;
            end
        end
        return m;
    endfunction

    always_comb begin
        // 17-bit sums so X+W-1 never wraps before the clamp.
        xe      = {1'b0, cmd_x} + {1'b0, cmd_w} - 17'd1;
        ye      = {1'b0, cmd_y} + {1'b0, cmd_h} - 17'd1;
        c_x1    = (xe > {1'b0, XMAX}) ? XMAX : xe[15:0];
        c_y1    = (ye > {1'b0, YMAX}) ? YMAX : ye[15:0];
        c_empty = (cmd_w == 16'd0) || (cmd_h == 16'd0) || (cmd_x > XMAX) || (cmd_y > YMAX);

        // CLIP sets up the first row straight from the clip results so the
        // first write appears two cycles after the last command byte.
        s_x1   = (state == S_CLIP) ? c_x1 : x1;
        s_y1   = (state == S_CLIP) ? c_y1 : y1;
        s_cy   = (state == S_CLIP) ? cmd_y : cy;
        s_edge = cmd_outline && (s_cy != cmd_y) && (s_cy != s_y1);
        s_wl   = cmd_x >> LW;
        s_wr   = s_x1 >> LW;
        s_lo   = int'(cmd_x & LMASK);
        s_hi   = int'(s_x1 & LMASK);

        // Word to present next: the row's first word when starting a row,
        // otherwise the successor of the word currently on the bus.
        if (state == S_DRIVE) pres_w = s_edge ? s_wr : cw + 16'd1;
        else                  pres_w = s_wl;

        row_lin   = 32'(BASE_ADDR) + 32'(s_cy) * 32'(WPR) + 32'(pres_w);
        pres_addr = ADDR_W'(row_lin);
        lane_m    = lanes(pres_w, s_wl, s_wr, s_lo, s_hi, s_edge);
        pres_wben = '0;
        for (int k = 0; k < PPW; k++) begin
            for (int j = 0; j < LB; j++) begin
                pres_wben[k*LB + j] = lane_m[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state       <= S_DECODE;
            byte_cnt    <= '0;
            cmd_x       <= '0;
            cmd_y       <= '0;
            cmd_w       <= '0;
            cmd_h       <= '0;
            cmd_outline <= 1'b0;
            cmd_color   <= '0;
            x1          <= '0;
            y1          <= '0;
            cy          <= '0;
            cw          <= '0;
            rtr_q       <= 1'b1;
            rts_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            wben_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_DECODE: begin
                    if (rtr_q && bus.cmd_fifo_rts) begin
                        busy_q <= 1'b1;
                        // Fields arrive MSB byte first; shift each byte in.
                        if (byte_cnt < CW'(2))       cmd_x <= {cmd_x[7:0], bus.cmd_fifo_data};
                        else if (byte_cnt < CW'(4))  cmd_y <= {cmd_y[7:0], bus.cmd_fifo_data};
                        else if (byte_cnt < CW'(6))  cmd_w <= {cmd_w[7:0], bus.cmd_fifo_data};
                        else if (byte_cnt < CW'(8))  cmd_h <= {cmd_h[7:0], bus.cmd_fifo_data};
                        else if (byte_cnt == CW'(8)) cmd_outline <= bus.cmd_fifo_data[0];
                        else cmd_color <= PIX_W'({cmd_color, bus.cmd_fifo_data});
                        if (byte_cnt == CW'(NBYTES - 1)) begin
                            byte_cnt <= '0;
                            rtr_q    <= 1'b0;
                            state    <= S_CLIP;
                        end else begin
                            byte_cnt <= byte_cnt + CW'(1);
                        end
                    end
                end
                S_CLIP: begin
                    x1     <= c_x1;
                    y1     <= c_y1;
                    cy     <= cmd_y;
                    data_q <= {PPW{cmd_color}};
                    if (c_empty) begin
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        cw     <= s_wl;
                        addr_q <= pres_addr;
                        wben_q <= pres_wben;
                        rts_q  <= 1'b1;
                        state  <= S_DRIVE;
                    end
                end
                S_ROW: begin
                    cw     <= s_wl;
                    addr_q <= pres_addr;
                    wben_q <= pres_wben;
                    rts_q  <= 1'b1;
                    state  <= S_DRIVE;
                end
                S_DRIVE: begin
                    // Outputs hold while the arbiter stalls; advance only on a transfer.
                    if (bus.arb_rtr) begin
                        if (cw == s_wr) begin
                            rts_q <= 1'b0;
                            if (cy == y1) begin
                                done_q <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                cy    <= cy + 16'd1;
                                state <= S_ROW;
                            end
                        end else begin
                            cw     <= pres_w;
                            addr_q <= pres_addr;
                            wben_q <= pres_wben;
                        end
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    rtr_q  <= 1'b1;
                    state  <= S_DECODE;
                end
                default: state <= S_DECODE;
            endcase
        end
    end

    assign bus.cmd_fifo_rtr = rtr_q;
    assign bus.arb_rts      = rts_q;
    assign bus.arb_addr     = addr_q;
    assign bus.arb_data     = data_q;
    assign bus.arb_wben     = wben_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule
